exp_normalizer: RTL and testbench
=================================

Name: exp_normalizer

Overview:
- Downstream consumer of parallel_exponent. Collects a vector of 64-bit exponent results and accumulates their sum.
- Then emits each element divided by the sum as an unsigned fixed-point fraction. This is the normalisation half of a softmax datapath.
- Input side is a valid/ready stream terminated by in_last. Output side is a valid/ready stream of normalised values.

Parameters:
- WIDTH, 64, bit width of each exponent result (Y from parallel_exponent).
- DEPTH, 8, maximum vector length held in the element buffer.
- FRAC, 16, number of fractional bits in each normalised output.

Ports:
- clk  input  1  single system clock; all state on rising edge.
- rst_n  input  1  asynchronous active-low reset.
- in_valid  input  1  in_data/in_last valid this cycle.
- in_ready  output  1  block accepts an element this cycle.
- in_data  input  WIDTH  exponent result, unsigned.
- in_last  input  1  marks final element of a vector.
- out_valid  output  1  out_data valid.
- out_ready  input  1  consumer accepts out_data.
- out_data  output  FRAC+1  floor((element << FRAC) / sum), unsigned.
- out_last  output  1  marks final normalised element of the vector.
- out_err  output  1  sum was zero for this vector (qualified by out_valid).

Behaviour:
- Reset (async, rst_n=0): state=ACCUM, count=0, sum=0, in_ready=1, out_valid=0, out_data=0, out_last=0, out_err=0. Reset mid-divide or mid-output discards the vector; no partial output follows.
- Sum width is WIDTH+clog2(DEPTH); it cannot overflow. Dividend width is WIDTH+FRAC.
- States: ACCUM, DIVIDE, OUTPUT.
- ACCUM:
  - in_ready=1.
  - On in_valid&in_ready: buf[count]<=in_data, sum<=sum+in_data, count++.
  - If in_last=1, or the accepted element fills the buffer (count reaches DEPTH), latch len and go to DIVIDE with idx=0.
  - A full buffer without in_last is an implicit last.
- DIVIDE:
  - in_ready=0.
  - Restoring divider, one quotient bit per cycle, exactly WIDTH+FRAC cycles per element, MSB first. Quotient is truncated (floor).
  - Quotient fits FRAC+1 bits because element<=sum. A single-element vector yields exactly 2^FRAC.
  - If sum==0, the divider is bypassed: quotient=0, err=1, still taking WIDTH+FRAC cycles so latency is fixed.
  - After the last iteration, go to OUTPUT.
- OUTPUT:
  - out_valid=1, with out_data, out_err and out_last=(idx==len-1) held stable while out_ready=0.
  - On out_ready=1:
    - If not last: idx++ and return to DIVIDE.
    - If last: clear sum/count and return to ACCUM.
- Latency: out_valid for element 0 rises WIDTH+FRAC+1 clock edges after the edge that accepts the last input. Each subsequent element follows WIDTH+FRAC+1 edges after the previous handshake.
- No input is accepted outside ACCUM; in_valid may stay high without loss.
- in_last on the DEPTH-th element is identical to the implicit case; there is no double-termination.

Decomposition:
- Shared package exp_pkg:
  - WIDTH/FRAC defaults.
  - Localparams SUM_W=WIDTH+clog2(DEPTH), DIV_CYC=WIDTH+FRAC, OUT_W=FRAC+1.
  - State enum {ACCUM, DIVIDE, OUTPUT}.
- One sub-module: seq_divider. It is a start/done restoring divider with parameters NUM_W and DEN_W, a divide-by-zero flag, and a fixed DIV_CYC latency.
- Buffer, accumulator and FSM stay in exp_normalizer.

Test Plan:
- Vector 1,1,2,4 (last on 4), out_ready=1 -> out_data 8192,8192,16384,32768; out_last only on the 4th; out_err=0.
- Single element 5 with in_last -> out_data 65536, out_last=1. out_valid rises exactly 81 edges after the accepting edge (WIDTH=64, FRAC=16).
- Eight elements of 3, no in_last -> in_ready drops after the 8th; eight outputs of 8192, out_last on the 8th.
- Vector 0,0,0 -> three outputs, out_data=0, out_err=1, out_last on the 3rd.
- Vector 1,3 with out_ready held 0 for 20 cycles at the first output -> out_data=16384 stable throughout; then 49152 after release.
- Assert rst_n=0 during DIVIDE of the 2nd element -> out_valid=0 and in_ready=1 immediately. A new vector 2,2 then yields 32768,32768.

Source files
------------

// File: rtl/exp_pkg.sv
// Shared types and sizing for the softmax normalisation block.
// Sizing localparams reflect the default configuration; modules derive their own from parameters.
package exp_pkg;

   localparam int WIDTH_DEF = 64;
   localparam int DEPTH_DEF = 8;
   localparam int FRAC_DEF  = 16;

   localparam int SUM_W   = WIDTH_DEF + $clog2(DEPTH_DEF);
   localparam int DIV_CYC = WIDTH_DEF + FRAC_DEF;
   localparam int OUT_W   = FRAC_DEF + 1;

   typedef enum logic [1:0] {
      ACCUM  = 2'd0,
      DIVIDE = 2'd1,
      OUTPUT = 2'd2
   } state_t;

   // Accumulator width that cannot overflow for `depth` elements of `width` bits.
   function automatic int sum_width(input int width, input int depth);
      return width + $clog2(depth);
   endfunction

endpackage

// File: rtl/exp_normalizer_if.sv
// Input and output valid/ready streams of the exponent normaliser.
interface exp_normalizer_if #(
   parameter int WIDTH = 64,
   parameter int FRAC  = 16
);
   logic             in_valid;
   logic             in_ready;
   logic [WIDTH-1:0] in_data;
   logic             in_last;
   logic             out_valid;
   logic             out_ready;
   logic [FRAC:0]    out_data;
   logic             out_last;
   logic             out_err;

   modport master (
      output in_valid, in_data, in_last, out_ready,
      input  in_ready, out_valid, out_data, out_last, out_err
   );

   modport slave (
      input  in_valid, in_data, in_last, out_ready,
      output in_ready, out_valid, out_data, out_last, out_err
   );
endinterface

// File: rtl/exp_normalizer_divider.sv
// Sequential restoring divider: one quotient bit per clock, NUM_W cycles total.
// Only the low Q_W quotient bits are kept; the caller guarantees the rest are zero.
module seq_divider #(
   parameter int NUM_W = 80,
   parameter int DEN_W = 67,
   parameter int Q_W   = 17
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic [NUM_W-1:0] num,
   input  logic [DEN_W-1:0] den,
   output logic [Q_W-1:0]   quot,
   output logic             div_zero,
   output logic             done
);
   localparam int CNT_W = $clog2(NUM_W + 1);

   logic [DEN_W-1:0] rem_reg;
   logic [NUM_W-1:0] num_reg;
   logic [DEN_W-1:0] den_reg;
   logic [Q_W-1:0]   quot_reg;
   logic [CNT_W-1:0] cnt_reg;
   logic             zero_reg;
   logic             busy_reg;
   logic             done_reg;

   logic [DEN_W-1:0] src_rem;
   logic [NUM_W-1:0] src_num;
   logic [DEN_W-1:0] src_den;
   logic [Q_W-1:0]   src_quot;
   logic             src_zero;
   logic [DEN_W:0]   trial;
   logic [DEN_W:0]   diff;
   logic             take;
   logic [DEN_W-1:0] rem_next;

   // The start cycle already performs the first iteration from the fresh operands.
   always_comb begin
      src_rem  = start ? '0 : rem_reg;
      src_num  = start ? num : num_reg;
      src_den  = start ? den : den_reg;
      src_quot = start ? '0 : quot_reg;
      src_zero = start ? (den == '0) : zero_reg;
      trial    = {src_rem, src_num[NUM_W-1]};
      diff     = trial - {1'b0, src_den};
      take     = !src_zero && (trial >= {1'b0, src_den});
      rem_next = take ? diff[DEN_W-1:0] : trial[DEN_W-1:0];
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rem_reg  <= '0;
         num_reg  <= '0;
         den_reg  <= '0;
         quot_reg <= '0;
         cnt_reg  <= '0;
         zero_reg <= 1'b0;
         busy_reg <= 1'b0;
         done_reg <= 1'b0;
      end else begin
         done_reg <= 1'b0;
         if (start || busy_reg) begin
            rem_reg  <= rem_next;
            num_reg  <= src_num << 1;
            quot_reg <= {src_quot[Q_W-2:0], take};
         end
         if (start) begin
            den_reg  <= den;
            zero_reg <= (den == '0);
            cnt_reg  <= CNT_W'(NUM_W - 1);
            busy_reg <= 1'b1;
         end else if (busy_reg) begin
            cnt_reg <= cnt_reg - CNT_W'(1);
            if (cnt_reg == CNT_W'(1)) begin
               busy_reg <= 1'b0;
               done_reg <= 1'b1;
            end
         end
      end
   end

   assign quot     = quot_reg;
   assign div_zero = zero_reg;
   assign done     = done_reg;

endmodule

// File: rtl/exp_normalizer.sv
// Softmax normaliser: buffers a vector of exponents, sums them, then streams
// floor((element << FRAC) / sum) for each element.
module exp_normalizer
   import exp_pkg::*;
#(
   parameter int WIDTH = WIDTH_DEF,
   parameter int DEPTH = DEPTH_DEF,
   parameter int FRAC  = FRAC_DEF
) (
   input  logic          clk,
   input  logic          rst_n,
   exp_normalizer_if.slave bus
);
   localparam int S_W   = sum_width(WIDTH, DEPTH);
   localparam int N_W   = WIDTH + FRAC;
   localparam int Q_W   = FRAC + 1;
   localparam int CNT_W = $clog2(DEPTH + 1);
   localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

   state_t           state_reg;
   logic [CNT_W-1:0] count_reg;
   logic [CNT_W-1:0] len_reg;
   logic [CNT_W-1:0] idx_reg;
   logic [S_W-1:0]   sum_reg;
   logic             start_reg;
   logic             in_ready_reg;
   logic             out_valid_reg;
   logic [Q_W-1:0]   out_data_reg;
   logic             out_last_reg;
   logic             out_err_reg;

   logic [WIDTH-1:0] elem_mem [DEPTH];

   logic             accept;
   logic             fill;
   logic [N_W-1:0]   div_num;
   logic [Q_W-1:0]   div_quot;
   logic             div_zero;
   logic             div_done;

   assign accept  = in_ready_reg && bus.in_valid;
   assign fill    = (count_reg == CNT_W'(DEPTH - 1));
   assign div_num = {elem_mem[idx_reg[IDX_W-1:0]], {FRAC{1'b0}}};

   always_ff @(posedge clk) begin
      if (accept) begin
         elem_mem[count_reg[IDX_W-1:0]] <= bus.in_data;
      end
   end

   seq_divider #(
      .NUM_W (N_W),
      .DEN_W (S_W),
      .Q_W   (Q_W)
   ) u_div (
      .clk      (clk),
      .rst_n    (rst_n),
      .start    (start_reg),
      .num      (div_num),
      .den      (sum_reg),
      .quot     (div_quot),
      .div_zero (div_zero),
      .done     (div_done)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_reg     <= ACCUM;
         count_reg     <= '0;
         len_reg       <= '0;
         idx_reg       <= '0;
         sum_reg       <= '0;
         start_reg     <= 1'b0;
         in_ready_reg  <= 1'b1;
         out_valid_reg <= 1'b0;
         out_data_reg  <= '0;
         out_last_reg  <= 1'b0;
         out_err_reg   <= 1'b0;
      end else begin
         start_reg <= 1'b0;
         case (state_reg)
            ACCUM: begin
               if (accept) begin
                  sum_reg   <= sum_reg + S_W'(bus.in_data);
                  count_reg <= count_reg + CNT_W'(1);
                  // A full buffer terminates the vector even without in_last.
                  if (bus.in_last || fill) begin
                     len_reg      <= count_reg + CNT_W'(1);
                     idx_reg      <= '0;
                     in_ready_reg <= 1'b0;
                     start_reg    <= 1'b1;
                     state_reg    <= DIVIDE;
                  end
               end
            end
            DIVIDE: begin
               if (div_done) begin
                  out_valid_reg <= 1'b1;
                  out_data_reg  <= div_quot;
                  out_err_reg   <= div_zero;
                  out_last_reg  <= (idx_reg == len_reg - CNT_W'(1));
                  state_reg     <= OUTPUT;
               end
            end
            OUTPUT: begin
               if (bus.out_ready) begin
                  out_valid_reg <= 1'b0;
                  if (out_last_reg) begin
                     sum_reg      <= '0;
                     count_reg    <= '0;
                     in_ready_reg <= 1'b1;
                     state_reg    <= ACCUM;
                  end else begin
                     idx_reg   <= idx_reg + CNT_W'(1);
                     start_reg <= 1'b1;
                     state_reg <= DIVIDE;
                  end
               end
            end
            default: begin
               state_reg <= ACCUM;
            end
         endcase
      end
   end

   assign bus.in_ready  = in_ready_reg;
   assign bus.out_valid = out_valid_reg;
   assign bus.out_data  = out_data_reg;
   assign bus.out_last  = out_last_reg;
   assign bus.out_err   = out_err_reg;

endmodule

// File: tb/tb_exp_normalizer.sv
// Scoreboard bench for exp_normalizer: driver pushes model results, monitor pops on each output handshake.
module tb_exp_normalizer;
   localparam int W   = 64;
   localparam int D   = 8;
   localparam int F   = 16;
   localparam int LAT = W + F + 1;

   typedef struct packed {
      logic [F:0] data;
      logic       last;
      logic       err;
   } exp_t;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   exp_normalizer_if #(.WIDTH(W), .FRAC(F)) bus ();

   exp_normalizer #(.WIDTH(W), .DEPTH(D), .FRAC(F)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   exp_t       sb_q[$];
   int         total = 0;
   int         bad = 0;
   int         cyc = 0;
   int         ready_mode = 0;
   bit         gaps = 1'b0;
   logic [W-1:0] vals [D];

   task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp_v);
      total++;
      if (act !== exp_v) begin
         bad++;
         $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp_v, cyc);
      end
   endtask

   task automatic bail(input string what);
      total++;
      bad++;
      $display("FAIL %s: timed out at cycle %0d", what, cyc);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   endtask

   // Reference: each output is floor(element * 2^F / sum), error flag when the sum is zero.
   task automatic push_expect(input int n);
      logic [127:0] s;
      logic [127:0] q;
      exp_t         e;
      s = '0;
      for (int i = 0; i < n; i++) s = s + 128'(vals[i]);
      for (int i = 0; i < n; i++) begin
         q      = (s == 0) ? 128'd0 : (128'(vals[i]) * (128'd1 << F)) / s;
         e.data = q[F:0];
         e.last = (i == n - 1);
         e.err  = (s == 0);
         sb_q.push_back(e);
      end
   endtask

   task automatic send_vector(input int n, input bit use_last);
      int w;
      push_expect(n);
      for (int i = 0; i < n; i++) begin
         if (gaps && $urandom_range(0, 3) == 0) begin
            bus.in_valid = 1'b0;
            repeat ($urandom_range(1, 3)) @(posedge clk);
            #1;
         end
         bus.in_valid = 1'b1;
         bus.in_data  = vals[i];
         bus.in_last  = use_last && (i == n - 1);
         w = 0;
         forever begin
            @(negedge clk);
            if (bus.in_ready) break;
            w++;
            if (w > 3000) bail("input accept");
         end
         @(posedge clk);
         #1;
      end
      bus.in_valid = 1'b0;
      bus.in_last  = 1'b0;
      chk("in_ready_after_last", bus.in_ready, 0);
   endtask

   task automatic wait_drain();
      int w;
      w = 0;
      while (sb_q.size() != 0) begin
         @(posedge clk);
         w++;
         if (w > 6000) bail("drain");
      end
      repeat (2) @(posedge clk);
      #1;
   endtask

   initial forever begin
      @(posedge clk);
      cyc++;
   end

   initial begin
      bus.out_ready = 1'b1;
      forever begin
         @(posedge clk);
         #1;
         case (ready_mode)
            1:       bus.out_ready = ($urandom_range(0, 2) != 0);
            2:       bus.out_ready = 1'b0;
            default: bus.out_ready = 1'b1;
         endcase
      end
   end

   // Monitor: latency from the terminating accept / previous handshake, hold stability, scoreboard pop.
   initial begin
      int   mon_cnt;
      int   ref_cyc;
      bit   prev_valid;
      bit   have_hold;
      exp_t hold;
      exp_t cur;
      exp_t e;
      mon_cnt = 0;
      ref_cyc = 0;
      prev_valid = 1'b0;
      have_hold = 1'b0;
      hold = '0;
      forever begin
         @(negedge clk);
         if (!rst_n) begin
            mon_cnt = 0;
            prev_valid = 1'b0;
            have_hold = 1'b0;
         end else begin
            if (bus.in_valid && bus.in_ready) begin
               mon_cnt++;
               if (bus.in_last || mon_cnt == D) begin
                  ref_cyc = cyc + 1;
                  mon_cnt = 0;
               end
            end
            if (bus.out_valid) begin
               cur = '{data: bus.out_data, last: bus.out_last, err: bus.out_err};
               if (!prev_valid) chk("latency", 128'(cyc - ref_cyc), LAT);
               if (have_hold) chk("stable", cur, hold);
               if (bus.out_ready) begin
                  if (sb_q.size() == 0) begin
                     total++;
                     bad++;
                     $display("FAIL unexpected_output: got data=%0d with nothing expected", bus.out_data);
                  end else begin
                     e = sb_q.pop_front();
                     chk("out_data", cur.data, e.data);
                     chk("out_last", cur.last, e.last);
                     chk("out_err", cur.err, e.err);
                  end
                  ref_cyc = cyc + 1;
                  have_hold = 1'b0;
               end else begin
                  have_hold = 1'b1;
                  hold = cur;
               end
            end
            prev_valid = bus.out_valid && !bus.out_ready;
         end
      end
   end

   initial begin
      #800000;
      bail("global watchdog");
   end

   initial begin
      int w;
      int n;
      bit use_last;
      bus.in_valid = 1'b0;
      bus.in_data  = '0;
      bus.in_last  = 1'b0;
      rst_n = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      chk("rst_in_ready", bus.in_ready, 1);
      chk("rst_out_valid", bus.out_valid, 0);
      chk("rst_out_data", bus.out_data, 0);
      chk("rst_out_last", bus.out_last, 0);
      chk("rst_out_err", bus.out_err, 0);
      rst_n = 1'b1;
      @(posedge clk);
      #1;

      // 1,1,2,4 terminated by in_last
      vals[0] = 1; vals[1] = 1; vals[2] = 2; vals[3] = 4;
      send_vector(4, 1'b1);
      wait_drain();

      // single element: exactly 2^F
      vals[0] = 5;
      send_vector(1, 1'b1);
      wait_drain();

      // full buffer without in_last
      for (int i = 0; i < D; i++) vals[i] = 3;
      send_vector(D, 1'b0);
      wait_drain();

      // in_last on the DEPTH-th element
      for (int i = 0; i < D; i++) vals[i] = 64'(i + 1);
      send_vector(D, 1'b1);
      wait_drain();

      // zero sum
      vals[0] = 0; vals[1] = 0; vals[2] = 0;
      send_vector(3, 1'b1);
      wait_drain();

      // back-pressure on the first output for 20 cycles
      ready_mode = 2;
      vals[0] = 1; vals[1] = 3;
      send_vector(2, 1'b1);
      w = 0;
      while (!bus.out_valid) begin
         @(negedge clk);
         w++;
         if (w > 200) bail("stall out_valid");
      end
      repeat (20) @(posedge clk);
      ready_mode = 0;
      wait_drain();

      // reset while the second element is dividing
      vals[0] = 1; vals[1] = 3;
      send_vector(2, 1'b1);
      w = 0;
      while (sb_q.size() != 1) begin
         @(posedge clk);
         w++;
         if (w > 300) bail("first of reset vector");
      end
      repeat (10) @(posedge clk);
      #1;
      rst_n = 1'b0;
      #1;
      chk("midreset_out_valid", bus.out_valid, 0);
      chk("midreset_in_ready", bus.in_ready, 1);
      sb_q.delete();
      repeat (2) @(posedge clk);
      #1;
      rst_n = 1'b1;
      @(posedge clk);
      #1;
      vals[0] = 2; vals[1] = 2;
      send_vector(2, 1'b1);
      wait_drain();

      // randomized vectors with gaps and random back-pressure
      ready_mode = 1;
      gaps = 1'b1;
      for (int v = 0; v < 20; v++) begin
         n = $urandom_range(1, D);
         use_last = (n < D) ? 1'b1 : 1'($urandom_range(0, 1));
         for (int i = 0; i < n; i++) begin
            case ($urandom_range(0, 3))
               0:       vals[i] = 64'($urandom_range(0, 15));
               1:       vals[i] = {$urandom, $urandom};
               2:       vals[i] = '0;
               default: vals[i] = 64'($urandom);
            endcase
         end
         send_vector(n, use_last);
      end
      wait_drain();
      ready_mode = 0;

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
